alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 129 ++++++++++++
 tb/tb_alu_exec_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Single-issue ALU execute stage: Addu/Subu/Nor/Sltu complete in one cycle,
// Srl shifts one bit per cycle with a valid/ready handshake on both sides.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  funct,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    localparam logic [5:0] F_ADDU = 6'b001001;
    localparam logic [5:0] F_SUBU = 6'b001010;
    localparam logic [5:0] F_NOR  = 6'b010011;
    localparam logic [5:0] F_SLTU = 6'b101010;
    localparam logic [5:0] F_SRL  = 6'b000010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shreg_q, shreg_d;

    logic [31:0] op_result;
    logic        op_illegal;
    logic        op_multi;

    // Decode of the single-cycle outcome; op_multi flags a Srl that needs the shifter.
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        op_multi   = 1'b0;
        case (funct)
            F_ADDU: op_result = src1 + src2;
            F_SUBU: op_result = src1 - src2;
            F_NOR:  op_result = ~(src1 | src2);
            F_SLTU: op_result = {31'b0, src1 < src2};
            F_SRL: begin
                op_result = src2;
                op_multi  = (shamt != 5'd0);
            end
            default: begin
                op_result  = '0;
                op_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op_multi) begin
                        state_d = SHIFT;
                        shreg_d = src2;
                        cnt_d   = shamt;
                    end else begin
                        state_d   = DONE;
                        result_d  = op_result;
                        zero_d    = (op_result == '0);
                        illegal_d = op_illegal;
                    end
                end
            end
            SHIFT: begin
                // result keeps the last completed value until the final shift lands
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d   = DONE;
                    result_d  = shreg_q >> 1;
                    zero_d    = ((shreg_q >> 1) == '0);
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against an arithmetic
// reference model of the ALU functions and handshake timing.
module tb_alu_exec_unit;

    localparam logic [5:0] F_ADDU = 6'b001001;
    localparam logic [5:0] F_SUBU = 6'b001010;
    localparam logic [5:0] F_NOR  = 6'b010011;
    localparam logic [5:0] F_SLTU = 6'b101010;
    localparam logic [5:0] F_SRL  = 6'b000010;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] last_res;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [5:0] f, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        case (f)
            F_ADDU:  return a + b;
            F_SUBU:  return a - b;
            F_NOR:   return ~(a | b);
            F_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            F_SRL:   return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_ill(input logic [5:0] f);
        return !(f == F_ADDU || f == F_SUBU || f == F_NOR || f == F_SLTU || f == F_SRL);
    endfunction

    task automatic scramble_inputs();
        funct = 6'($urandom);
        src1  = $urandom;
        src2  = $urandom;
        shamt = 5'($urandom);
    endtask

    // Called at posedge+1. Issues one request, waits for the result, holds it
    // for 'hold' cycles under backpressure, then releases with in_valid still high.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input int unsigned hold);
        logic [31:0] er;
        logic        ei;
        int unsigned ew;
        int unsigned waits;
        er = model_res(f, a, b, sh);
        ei = model_ill(f);
        ew = (f == F_SRL) ? 32'(sh) : 0;
        check("ready_before", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        funct     = f;
        src1      = a;
        src2      = b;
        shamt     = sh;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        waits = 0;
        while (out_valid !== 1'b1 && waits < 40) begin
            check("busy_ready", {31'b0, in_ready}, 32'd0);
            check("busy_hold", result, last_res);
            in_valid = 1'($urandom);
            scramble_inputs();
            @(posedge clk); #1;
            waits++;
        end
        in_valid = 1'b0;
        check("latency", waits, ew);
        check("result", result, er);
        check("zero", {31'b0, zero}, {31'b0, er == 32'd0});
        check("illegal", {31'b0, illegal}, {31'b0, ei});
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result", result, er);
            check("bp_zero", {31'b0, zero}, {31'b0, er == 32'd0});
            check("bp_illegal", {31'b0, illegal}, {31'b0, ei});
        end
        last_res  = er;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct     = F_ADDU;
        @(posedge clk); #1;
        check("release_valid", {31'b0, out_valid}, 32'd0);
        check("release_idle", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [5:0]  rf;
        logic [4:0]  rsh;
        int unsigned sel;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct     = '0;
        src1      = '0;
        src2      = '0;
        shamt     = '0;
        last_res  = '0;
        #1;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // first request right after reset release, wrap-around add
        run_op(F_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
        run_op(F_SLTU, 32'd5, 32'h8000_0000, 5'd0, 1);
        run_op(F_SLTU, 32'h8000_0000, 32'd5, 5'd0, 0);
        run_op(F_SUBU, 32'd3, 32'd5, 5'd0, 0);
        run_op(F_SRL, 32'd0, 32'h8000_0001, 5'd31, 0);
        run_op(F_SRL, 32'd0, 32'h8000_0001, 5'd0, 0);
        run_op(F_NOR, 32'd0, 32'd0, 5'd0, 5);
        run_op(F_ADDU, 32'd10, 32'd20, 5'd0, 0);
        run_op(F_SRL, 32'd0, 32'hFFFF_FFFF, 5'd1, 2);
        run_op(6'b000000, 32'd7, 32'd9, 5'd3, 1);
        run_op(F_SLTU, 32'd1, 32'd2, 5'd0, 0);

        // abort a long shift with an asynchronous reset
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        funct    = F_SRL;
        src2     = 32'hDEAD_BEEF;
        shamt    = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", {31'b0, zero}, 32'd0);
        check("abort_illegal", {31'b0, illegal}, 32'd0);
        check("abort_ready_after", {31'b0, in_ready}, 32'd1);
        #3 rst = 1'b0;
        last_res = '0;
        repeat (30) begin
            @(posedge clk); #1;
            check("abort_no_valid", {31'b0, out_valid}, 32'd0);
        end

        run_op(F_SRL, 32'd0, 32'h0000_F000, 5'd12, 1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: rf = F_ADDU;
                1: rf = F_SUBU;
                2: rf = F_NOR;
                3: rf = F_SLTU;
                4: rf = F_SRL;
                default: rf = 6'($urandom);
            endcase
            rsh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op(rf, $urandom, $urandom, rsh, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
